seg_scan_decoder: RTL
=====================

# seg_scan_decoder

Receive-side counterpart to the counter's multiplexed seven-segment driver. Samples the eight common-select lines and seven segment lines, identifies which digit is lit, and captures a debounced hex value per digit. Reconstructs the displayed 8-digit value and flags malformed scan activity. Used as an on-chip/bench readback monitor of the display bus.

## Interface
- `STABLE_CYCLES`, 4: consecutive identical samples required before a digit is captured; legal range ≥2.
- `SEG_ACTIVE_LOW`, 1: segment lines lit when 0.
- `COM_ACTIVE_LOW`, 1: common lines select when 0.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `SEGA`..`SEGG`  in  1 each  segment lines a..g.
- `SEGCOM1`..`SEGCOM8`  in  1 each  digit selects; COM1 = digit 0 (least significant nibble).
- `err_clr`  in  1  synchronous clear of sticky error flags.
- `digits`  out  32  captured nibbles, digit i at [4i+3:4i].
- `digit_valid`  out  8  digit i holds a decoded hex value.
- `digit_blank`  out  8  digit i last captured all-segments-off.
- `frame_done`  out  1  one-cycle pulse when all 8 digits captured since last pulse.
- `err_pattern`  out  1  sticky: non-hex, non-blank pattern captured.
- `err_multi_com`  out  1  sticky: more than one select active.

## Operation
- All 15 inputs pass a 2-flop synchronizer, then polarity-normalised to active-high internally (seg bits {g,f,e,d,c,b,a}).
- Select decode: exactly one COM active → `idx` 0..7, `active`=1. None active → blanking gap; stability counter cleared. More than one → `err_multi_com` set, counter cleared, no capture.
- Stability counter: increments while `active` and (idx, seg) equal previous cycle; reloads to 1 on any change; saturates at `STABLE_CYCLES`. Capture fires once, on the cycle the counter reaches `STABLE_CYCLES`; no re-capture during the same dwell.
- Capture, pattern p:
  - hex table 0x3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71 → nibble 0..F: write `digits[idx]`, set `digit_valid[idx]`, clear `digit_blank[idx]`.
  - p = 0x00: `digits[idx]`←0, set `digit_blank[idx]`, clear `digit_valid[idx]`.
  - other: leave `digits[idx]`, clear both bits for idx, set `err_pattern`.
- Seen mask: bit idx set on every capture (any outcome). When a capture makes mask all-ones, `frame_done` pulses next cycle and mask clears in the same edge.
- `err_clr` clears both sticky flags; a new error in the same cycle wins (flag stays 1).

## Timing
- Reset values: `digits`=0, `digit_valid`=0, `digit_blank`=0, `frame_done`=0, both errors 0, counter 0, seen mask 0.
- Latency: pattern stable at pins from edge t → outputs updated at edge t + 2 + `STABLE_CYCLES`.
- `frame_done` asserted exactly 1 cycle, edge after the completing capture's output update.
- Glitch shorter than `STABLE_CYCLES` samples: never captured, no error (except multi-COM, flagged immediately after sync).
- Same digit revisited after a gap or different pattern: new dwell, captured again, overwrites.
- Reset mid-dwell: all state cleared asynchronously; capture restarts from counter 0 after release.

## Structure
- Package `seg_pkg`: 7-bit segment pattern constants for 0..F and blank, digit count (8), nibble width.
- Sub-module `seg7_to_hex`: combinational p → {nibble, is_hex, is_blank}; instantiated once.

## Test plan
- Scan digits 0..7 with values 1,2,3,4,5,6,7,8, 6-cycle dwell each → `digits`=0x87654321, `digit_valid`=0xFF, one `frame_done` pulse.
- Digit 3 shows 0x7F held for 3 cycles only (STABLE_CYCLES=4) → no change to digit 3, no error.
- Digit 2 shows pattern 0x49 for 6 cycles → `err_pattern`=1, `digit_valid[2]`=0; `err_clr` pulse → 0.
- SEGCOM1 and SEGCOM5 low together → `err_multi_com`=1 three cycles later, no capture.
- Digit 7 all segments off → `digit_blank[7]`=1, `digits[31:28]`=0; then 0x71 → nibble F, blank cleared.
- `reset` low mid-dwell after partial frame → all outputs 0; full rescan yields single `frame_done`.

Source files
------------

// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg_pkg
//  Description : Shared types, segment pattern constants and helpers for the
//                seven-segment scan decoder.
//  Revision    : 1.0  initial release
// ============================================================================
package seg_pkg;

    localparam int DIGITS   = 8;
    localparam int NIBBLE_W = 4;
    localparam int SEG_W    = 7;
    localparam int HEX_VALS = 16;

    // Segment pattern, bit order {g,f,e,d,c,b,a}, active-high
    typedef logic [SEG_W-1:0]      seg_t;
    typedef logic [NIBBLE_W-1:0]   nibble_t;
    typedef logic [$clog2(DIGITS)-1:0] digit_idx_t;

    // Result of classifying one captured segment pattern
    typedef struct packed {
        nibble_t nibble;
        logic    is_hex;
        logic    is_blank;
    } seg_decode_t;

    localparam seg_t SEG_BLANK = 7'h00;
    localparam seg_t SEG_HEX_0 = 7'h3F;
    localparam seg_t SEG_HEX_1 = 7'h06;
    localparam seg_t SEG_HEX_2 = 7'h5B;
    localparam seg_t SEG_HEX_3 = 7'h4F;
    localparam seg_t SEG_HEX_4 = 7'h66;
    localparam seg_t SEG_HEX_5 = 7'h6D;
    localparam seg_t SEG_HEX_6 = 7'h7D;
    localparam seg_t SEG_HEX_7 = 7'h07;
    localparam seg_t SEG_HEX_8 = 7'h7F;
    localparam seg_t SEG_HEX_9 = 7'h6F;
    localparam seg_t SEG_HEX_A = 7'h77;
    localparam seg_t SEG_HEX_B = 7'h7C;
    localparam seg_t SEG_HEX_C = 7'h39;
    localparam seg_t SEG_HEX_D = 7'h5E;
    localparam seg_t SEG_HEX_E = 7'h79;
    localparam seg_t SEG_HEX_F = 7'h71;

    // Forward map nibble -> segment pattern; the decoder searches it in reverse
    function automatic seg_t hex_to_seg(input nibble_t n);
        seg_t s;
        case (n)
            4'h0:    s = SEG_HEX_0;
            4'h1:    s = SEG_HEX_1;
            4'h2:    s = SEG_HEX_2;
            4'h3:    s = SEG_HEX_3;
            4'h4:    s = SEG_HEX_4;
            4'h5:    s = SEG_HEX_5;
            4'h6:    s = SEG_HEX_6;
            4'h7:    s = SEG_HEX_7;
            4'h8:    s = SEG_HEX_8;
            4'h9:    s = SEG_HEX_9;
            4'hA:    s = SEG_HEX_A;
            4'hB:    s = SEG_HEX_B;
            4'hC:    s = SEG_HEX_C;
            4'hD:    s = SEG_HEX_D;
            4'hE:    s = SEG_HEX_E;
            default: s = SEG_HEX_F;
        endcase
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_to_hex.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_to_hex
//  Description : Combinational classifier of a seven-segment pattern into a
//                hex nibble, an all-off blank, or neither (malformed).
//  Revision    : 1.0  initial release
// ============================================================================
module seg7_to_hex
    import seg_pkg::*;
(
    input  seg_t        seg_i,
    output seg_decode_t dec_o
);

    // Reverse lookup of the hex table; the table has no duplicate entries
    always_comb begin
        dec_o          = '0;
        dec_o.is_blank = (seg_i == SEG_BLANK);
        for (int i = 0; i < HEX_VALS; i++) begin
            if (seg_i == hex_to_seg(NIBBLE_W'(i))) begin
                dec_o.nibble = NIBBLE_W'(i);
                dec_o.is_hex = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/seg_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_decoder
//  Description : Monitors a multiplexed 8-digit seven-segment display bus,
//                debounces each digit dwell and reconstructs the displayed
//                32-bit hex value, flagging malformed scan activity.
//  Revision    : 1.0  initial release
// ============================================================================
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit COM_ACTIVE_LOW = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       SEGA,
    input  logic                       SEGB,
    input  logic                       SEGC,
    input  logic                       SEGD,
    input  logic                       SEGE,
    input  logic                       SEGF,
    input  logic                       SEGG,
    input  logic                       SEGCOM1,
    input  logic                       SEGCOM2,
    input  logic                       SEGCOM3,
    input  logic                       SEGCOM4,
    input  logic                       SEGCOM5,
    input  logic                       SEGCOM6,
    input  logic                       SEGCOM7,
    input  logic                       SEGCOM8,
    input  logic                       err_clr,
    output logic [DIGITS*NIBBLE_W-1:0] digits,
    output logic [DIGITS-1:0]          digit_valid,
    output logic [DIGITS-1:0]          digit_blank,
    output logic                       frame_done,
    output logic                       err_pattern,
    output logic                       err_multi_com
);

    localparam int RAW_W = SEG_W + DIGITS;
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);
    // Idle bus level: nothing selected, nothing lit
    localparam logic [RAW_W-1:0] C_RAW_IDLE =
        {{DIGITS{COM_ACTIVE_LOW}}, {SEG_W{SEG_ACTIVE_LOW}}};

    // ------------------------------------------------------------------
    // Input synchronisation and polarity normalisation
    // ------------------------------------------------------------------
    logic [RAW_W-1:0] w_raw;
    logic [RAW_W-1:0] sync1_q;
    logic [RAW_W-1:0] sync2_q;
    seg_t             w_seg;
    logic [DIGITS-1:0] w_com;

    assign w_raw = {SEGCOM8, SEGCOM7, SEGCOM6, SEGCOM5,
                    SEGCOM4, SEGCOM3, SEGCOM2, SEGCOM1,
                    SEGG, SEGF, SEGE, SEGD, SEGC, SEGB, SEGA};

    // Two-flop synchroniser; resets to idle so release does not look like a multi-select
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= C_RAW_IDLE;
            sync2_q <= C_RAW_IDLE;
        end else begin
            sync1_q <= w_raw;
            sync2_q <= sync1_q;
        end
    end

    assign w_seg = sync2_q[SEG_W-1:0]     ^ {SEG_W{SEG_ACTIVE_LOW}};
    assign w_com = sync2_q[RAW_W-1:SEG_W] ^ {DIGITS{COM_ACTIVE_LOW}};

    // ------------------------------------------------------------------
    // Select decode
    // ------------------------------------------------------------------
    logic [$clog2(DIGITS+1)-1:0] w_com_cnt;
    digit_idx_t                  w_com_idx;
    logic                        w_com_active;
    logic                        w_com_multi;

    // Count active selects and remember the (only meaningful when single) index
    always_comb begin
        w_com_cnt = '0;
        w_com_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_com[i]) begin
                w_com_cnt = w_com_cnt + 1'b1;
                w_com_idx = digit_idx_t'(i);
            end
        end
    end

    assign w_com_active = (w_com_cnt == 1);
    assign w_com_multi  = (w_com_cnt > 1);

    // ------------------------------------------------------------------
    // Dwell stability counter
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q, cnt_d;
    digit_idx_t       prev_idx_q;
    seg_t             prev_seg_q;
    logic             cap_q, cap_d;

    // Count identical single-select samples; any change restarts, gaps/multi clear
    always_comb begin
        cnt_d = '0;
        if (w_com_active) begin
            if ((cnt_q != '0) && (w_com_idx == prev_idx_q) && (w_seg == prev_seg_q)) begin
                cnt_d = (cnt_q == C_CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            end else begin
                cnt_d = C_CNT_ONE;
            end
        end
        // Only the transition into saturation captures, so one dwell gives one capture
        cap_d = (cnt_d == C_CNT_MAX) && (cnt_q != C_CNT_MAX);
    end

    // Counter state plus the sample it compares against; prev_* also names the capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            prev_idx_q <= '0;
            prev_seg_q <= '0;
            cap_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            prev_idx_q <= w_com_idx;
            prev_seg_q <= w_seg;
            cap_q      <= cap_d;
        end
    end

    // ------------------------------------------------------------------
    // Pattern classification of the captured sample
    // ------------------------------------------------------------------
    seg_decode_t w_dec;

    seg7_to_hex u_seg7_to_hex (
        .seg_i (prev_seg_q),
        .dec_o (w_dec)
    );

    // ------------------------------------------------------------------
    // Digit store, frame tracking and sticky errors
    // ------------------------------------------------------------------
    logic [DIGITS*NIBBLE_W-1:0] digits_q, digits_d;
    logic [DIGITS-1:0]          valid_q, valid_d;
    logic [DIGITS-1:0]          blank_q, blank_d;
    logic [DIGITS-1:0]          seen_q, seen_d;
    logic [DIGITS-1:0]          w_seen_next;
    logic                       full_q, full_d;
    logic                       frame_done_q;
    logic                       err_pat_q, err_pat_d;
    logic                       err_multi_q, err_multi_d;

    // Apply a capture to the digit store and update frame/error bookkeeping
    always_comb begin
        digits_d    = digits_q;
        valid_d     = valid_q;
        blank_d     = blank_q;
        seen_d      = seen_q;
        full_d      = 1'b0;
        w_seen_next = seen_q;
        // A fresh error in the same cycle as err_clr keeps the flag set
        err_pat_d   = err_pat_q & ~err_clr;
        err_multi_d = (err_multi_q & ~err_clr) | w_com_multi;

        if (cap_q) begin
            if (w_dec.is_hex) begin
                digits_d[{prev_idx_q, 2'b00} +: NIBBLE_W] = w_dec.nibble;
                valid_d[prev_idx_q] = 1'b1;
                blank_d[prev_idx_q] = 1'b0;
            end else if (w_dec.is_blank) begin
                digits_d[{prev_idx_q, 2'b00} +: NIBBLE_W] = '0;
                valid_d[prev_idx_q] = 1'b0;
                blank_d[prev_idx_q] = 1'b1;
            end else begin
                valid_d[prev_idx_q] = 1'b0;
                blank_d[prev_idx_q] = 1'b0;
                err_pat_d           = 1'b1;
            end

            // Every capture counts toward the frame, whatever its outcome
            w_seen_next             = seen_q;
            w_seen_next[prev_idx_q] = 1'b1;
            if (&w_seen_next) begin
                seen_d = '0;
                full_d = 1'b1;
            end else begin
                seen_d = w_seen_next;
            end
        end
    end

    // Output registers; frame_done trails the completing capture by one edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digits_q     <= '0;
            valid_q      <= '0;
            blank_q      <= '0;
            seen_q       <= '0;
            full_q       <= 1'b0;
            frame_done_q <= 1'b0;
            err_pat_q    <= 1'b0;
            err_multi_q  <= 1'b0;
        end else begin
            digits_q     <= digits_d;
            valid_q      <= valid_d;
            blank_q      <= blank_d;
            seen_q       <= seen_d;
            full_q       <= full_d;
            frame_done_q <= full_q;
            err_pat_q    <= err_pat_d;
            err_multi_q  <= err_multi_d;
        end
    end

    assign digits        = digits_q;
    assign digit_valid   = valid_q;
    assign digit_blank   = blank_q;
    assign frame_done    = frame_done_q;
    assign err_pattern   = err_pat_q;
    assign err_multi_com = err_multi_q;

endmodule
`default_nettype wire
